// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin arbiter letting NUM_CH thread channels share the
// single-ported lsu memory stage. One operation in flight at a time; each
// operation runs IDLE (accept) -> ISSUE (strobe) -> WAIT (capture) -> RESPOND.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/write   per-channel request valid / store select
//   req_addr/wdata    packed per-channel payload, channel i at [i*W +: W]
//   req_ready         one-hot accept (combinational, IDLE only)
//   rsp_valid         one-hot one-cycle response pulse
//   rsp_data          load data for the responding channel, 0 for stores
//   lsu_*             command/response port to the lsu stage
module lsu_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        lsu_address,
  output logic [DATA_W-1:0]        lsu_write_data,
  output logic                     lsu_mem_write,
  output logic                     lsu_mem_read,
  input  logic [DATA_W-1:0]        lsu_read_data,
  input  logic                     lsu_busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                         state, state_nxt;
  logic [CH_W-1:0]                rr_ptr, gnt_q, win;
  logic                           any_vld, accept, wr_q;
  logic [NUM_CH-1:0][ADDR_W-1:0]  addr_a;
  logic [NUM_CH-1:0][DATA_W-1:0]  wdata_a;

  // Per-channel payload unpack and one-hot grant/response decode.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign addr_a[i]    = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i]   = req_wdata[i*DATA_W +: DATA_W];
    assign req_ready[i] = accept && (win == CH_W'(i));
    assign rsp_valid[i] = (state == RESPOND) && (gnt_q == CH_W'(i));
  end

  // Scan from rr_ptr upward (mod NUM_CH). Walking the offsets from the far
  // end down lets the nearest valid channel overwrite any farther one.
  always_comb begin
    logic [CH_W:0] sum;
    win     = '0;
    any_vld = 1'b0;
    sum     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (req_valid[sum[CH_W-1:0]]) begin
        win     = sum[CH_W-1:0];
        any_vld = 1'b1;
      end
    end
  end

  // Reset gates the grant so req_ready can never fire during reset.
  assign accept = (state == IDLE) && !reset && !lsu_busy && any_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      gnt_q          <= '0;
      wr_q           <= 1'b0;
      lsu_address    <= '0;
      lsu_write_data <= '0;
      rsp_data       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_q          <= win;
        wr_q           <= req_write[win];
        lsu_address    <= addr_a[win];
        lsu_write_data <= wdata_a[win];
        rr_ptr         <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
      end
      if (state == WAIT) rsp_data <= wr_q ? '0 : lsu_read_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    lsu_mem_read  = 1'b0;
    lsu_mem_write = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE: begin
        lsu_mem_write = wr_q;
        lsu_mem_read  = !wr_q;
        state_nxt     = WAIT;
      end
      WAIT:    state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
module tb_lsu_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [N*8-1:0] req_addr, req_wdata;
  logic [7:0]     rsp_data, lsu_address, lsu_write_data, lsu_read_data;
  logic           lsu_mem_write, lsu_mem_read, lsu_busy;

  lsu_arbiter #(.NUM_CH(N), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .lsu_address(lsu_address), .lsu_write_data(lsu_write_data),
    .lsu_mem_write(lsu_mem_write), .lsu_mem_read(lsu_mem_read),
    .lsu_read_data(lsu_read_data), .lsu_busy(lsu_busy)
  );

  always #5 clk = ~clk;

  // lsu model: read data valid the cycle after the strobe, busy high in that
  // same cycle. Memory is preloaded while reset is held.
  logic [7:0] mem [256];
  logic [7:0] rd_q;
  logic       busy_q, busy_force;
  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
      mem[8'h00] <= 8'h11; mem[8'h01] <= 8'h22;
      mem[8'h02] <= 8'h33; mem[8'h03] <= 8'h44;
      mem[8'h20] <= 8'hA5;
      busy_q <= 1'b0;
      rd_q   <= 8'h00;
    end else begin
      if (lsu_mem_write) mem[lsu_address] <= lsu_write_data;
      if (lsu_mem_read)  rd_q <= mem[lsu_address];
      busy_q <= lsu_mem_read | lsu_mem_write;
    end
  end
  assign lsu_read_data = rd_q;
  assign lsu_busy      = busy_q | busy_force;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         ch;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  // One full transaction from IDLE, checking every stage of its timeline.
  task automatic do_txn(input vec_t v);
    req_valid = '0;
    req_valid[v.ch] = 1'b1;
    req_write[v.ch] = v.wr;
    req_addr[v.ch*8 +: 8]  = v.addr;
    req_wdata[v.ch*8 +: 8] = v.wdata;
    #1;
    chk("txn_ready", req_ready, 32'(1 << v.ch));
    step();
    req_valid = '0;
    chk("txn_issue_rd", lsu_mem_read, !v.wr);
    chk("txn_issue_wr", lsu_mem_write, v.wr);
    chk("txn_issue_addr", lsu_address, v.addr);
    if (v.wr) chk("txn_issue_wdata", lsu_write_data, v.wdata);
    step();
    chk("txn_wait_strobes", {lsu_mem_read, lsu_mem_write}, 0);
    step();
    chk("txn_rsp_valid", rsp_valid, 32'(1 << v.ch));
    chk("txn_rsp_data", rsp_data, v.exp);
    step();
    chk("txn_rsp_done", rsp_valid, 0);
  endtask

  initial begin
    vecs[0] = '{ch: 1, wr: 1'b0, addr: 8'h20, wdata: 8'h00, exp: 8'hA5};
    vecs[1] = '{ch: 0, wr: 1'b1, addr: 8'h10, wdata: 8'h3C, exp: 8'h00};
    vecs[2] = '{ch: 0, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'h3C};
    vecs[3] = '{ch: 3, wr: 1'b1, addr: 8'hFF, wdata: 8'h5A, exp: 8'h00};
    vecs[4] = '{ch: 2, wr: 1'b0, addr: 8'hFF, wdata: 8'h00, exp: 8'h5A};

    reset = 1'b1; busy_force = 1'b0;
    req_valid = 4'b0001; req_write = '0; req_addr = '0; req_wdata = '0;
    step(); step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {lsu_mem_read, lsu_mem_write}, 0);
    chk("rst_addr", lsu_address, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 1'b0; req_valid = '0;
    step();

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Four-way contention from reset: grants 0,1,2,3 every four cycles.
    reset = 1'b1; step(); reset = 1'b0;
    req_write = '0; req_addr = {8'h03, 8'h02, 8'h01, 8'h00}; req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", req_ready, 32'(1 << i));
      step();
      req_valid[i] = 1'b0;
      step(); step();
      chk("cont_rsp_valid", rsp_valid, 32'(1 << i));
      chk("cont_rsp_data", rsp_data, 32'(8'h11 * (i + 1)));
      step();
    end

    // Fairness/wrap: after channel 2 is granted, 3 beats 0.
    req_valid = 4'b0100;
    #1;
    chk("fair_ch2", req_ready, 32'b0100);
    step();
    req_valid = 4'b1001;
    step(); step(); step();
    chk("fair_ch3_first", req_ready, 32'b1000);
    step();
    req_valid[3] = 1'b0;
    step(); step();
    chk("fair_ch3_rsp", rsp_data, 32'h44);
    step();
    chk("fair_ch0_wrap", req_ready, 32'b0001);
    step();
    req_valid = '0;
    step(); step(); step();

    // Busy interlock: no grant while lsu_busy, grant on first free cycle.
    busy_force = 1'b1;
    req_valid = 4'b0100; req_addr[2*8 +: 8] = 8'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_hold", req_ready, 0);
      step();
    end
    busy_force = 1'b0;
    #1;
    chk("busy_release", req_ready, 32'b0100);
    step();
    req_valid = '0;
    step(); step();
    chk("busy_rsp", {rsp_valid, rsp_data}, {4'b0100, 8'hA5});
    step();

    // Reset in WAIT: operation dropped, state back to reset values.
    req_valid = 4'b0010; req_addr[1*8 +: 8] = 8'h03;
    #1;
    chk("rstmid_accept", req_ready, 32'b0010);
    step();
    req_valid = '0;
    step();
    reset = 1'b1; req_valid = 4'b0010;
    step();
    chk("rstmid_ready", req_ready, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_strobes", {lsu_mem_read, lsu_mem_write}, 0);
    chk("rstmid_addr", lsu_address, 0);
    chk("rstmid_wdata", lsu_write_data, 0);
    chk("rstmid_rsp_data", rsp_data, 0);
    reset = 1'b0; req_valid = 4'b1011;
    #1;
    chk("rstmid_prio0", req_ready, 32'b0001);
    step();
    req_valid = 4'b1010;
    chk("rstmid_no_rsp", rsp_valid, 0);
    step(); step();
    chk("rstmid_ch0_rsp", {rsp_valid, rsp_data}, {4'b0001, 8'h11});
    step();
    chk("rstmid_ch1_next", req_ready, 32'b0010);
    step();
    req_valid = '0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Round-robin arbiter that lets NUM_CH thread channels share the single-ported `lsu` memory stage. It sits directly upstream of `lsu`. It accepts one load/store request per grant over a valid/ready handshake and drives the `lsu` command port for exactly one cycle. It then captures `read_data` and returns a one-cycle response pulse to the granted channel. Only one operation is in flight at a time.

## Interface

Parameters:
- `NUM_CH`, default 4: number of requesting channels (≥2)
- `ADDR_W`, default 8: address width; must match `lsu`
- `DATA_W`, default 8: data width; must match `lsu`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_CH  per-channel request valid
- `req_write`  in  NUM_CH  1 = store, 0 = load
- `req_addr`  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NUM_CH*DATA_W  packed store data
- `req_ready`  out  NUM_CH  one-hot grant/accept; combinational
- `rsp_valid`  out  NUM_CH  one-hot response pulse
- `rsp_data`  out  DATA_W  load data for the pulsing channel; 0 for stores
- `lsu_address`  out  ADDR_W  to `lsu.address`
- `lsu_write_data`  out  DATA_W  to `lsu.write_data`
- `lsu_mem_write`  out  1  to `lsu.mem_write`
- `lsu_mem_read`  out  1  to `lsu.mem_read`
- `lsu_read_data`  in  DATA_W  from `lsu.read_data`
- `lsu_busy`  in  1  from `lsu.busy`

## Operation

- FSM states: IDLE → ISSUE → WAIT → RESPOND → IDLE.
- **IDLE**
  - If `lsu_busy`=0 and any `req_valid`, pick the winner g: the first valid channel scanning from `rr_ptr` upward, modulo NUM_CH.
  - Assert `req_ready[g]` combinationally.
  - On the clock edge, latch g, `req_write[g]`, `req_addr[g]` and `req_wdata[g]`; set `rr_ptr` to (g+1) mod NUM_CH; go to ISSUE.
  - If no channel is valid, or `lsu_busy`=1, stay in IDLE with `req_ready` all zero.
- **ISSUE**
  - Drive `lsu_address` and `lsu_write_data` from the latched values.
  - Assert exactly one of `lsu_mem_write` or `lsu_mem_read`, per the latched `req_write`.
  - Go to WAIT.
- **WAIT**
  - Both command strobes are 0.
  - `lsu_read_data` is valid this cycle. On the clock edge, register it into `rsp_data` for a load, or 0 for a store.
  - Go to RESPOND.
- **RESPOND**
  - `rsp_valid[g]`=1 for exactly one cycle, with `rsp_data` held stable.
  - Go to IDLE.
- `req_ready` is nonzero only in IDLE, and is never asserted while `reset`=1.
- Channel rule: once a channel raises `req_valid`, it holds valid and its payload stable until it sees `req_ready`. The arbiter samples the payload only in the accept cycle.
- `lsu_address` and `lsu_write_data` are registered outputs. Outside ISSUE they keep their last value.
- `rsp_data` holds its value until the next RESPOND.
- Round-robin pointer behaviour:
  - `rr_ptr` resets to 0, so channel 0 has highest priority.
  - It updates only on a grant.
  - It wraps from NUM_CH-1 to 0.
- Reset is synchronous and has priority over every state.
  - Reset values: state = IDLE, `rr_ptr` = 0, `lsu_mem_read` = `lsu_mem_write` = 0, `lsu_address` = 0, `lsu_write_data` = 0, `rsp_valid` = 0, `rsp_data` = 0, `req_ready` = 0.
  - An in-flight request is dropped with no response. If ISSUE had already fired, the `lsu` memory write may have completed.

## Timing

- Accept cycle t (IDLE, `req_valid[g]` & `req_ready[g]`):
  - t+1: command strobe high
  - t+2: `lsu_read_data` valid
  - t+3: `rsp_valid[g]`=1
- Next accept is possible at t+4. Peak throughput is one operation per 4 cycles.
- `lsu` busy timing: `lsu_busy` rises after the ISSUE edge and falls after the WAIT edge, so it is 0 again in RESPOND. The busy gate in IDLE is a safety interlock only; in normal operation it never stalls.
- A channel may re-request in the cycle after its `rsp_valid`. It is granted again only after the other valid channels have been served.

## Test plan

- **Single load:** memory[0x20]=0xA5. Channel 1 issues a load to 0x20 at cycle t. Required: `req_ready`=0b0010 at t; `lsu_mem_read`=1 with `lsu_address`=0x20 at t+1 only; `rsp_valid`=0b0010 with `rsp_data`=0xA5 at t+3.
- **Store then load:** channel 0 stores 0x3C to 0x10, then loads 0x10. Required: `lsu_mem_write`=1 with `lsu_write_data`=0x3C for one cycle; store response has `rsp_data`=0; load response has `rsp_data`=0x3C.
- **Four-way contention:** all four channels request loads from 0x00–0x03 (holding 0x11, 0x22, 0x33, 0x44) from reset. Required: grants to channels 0, 1, 2, 3 at t, t+4, t+8, t+12; responses 0x11, 0x22, 0x33, 0x44 on the matching one-hot `rsp_valid`.
- **Fairness and wrap:** after channel 2 is granted, channels 0 and 3 are valid. Required: channel 3 is granted first, then channel 0.
- **Busy interlock:** force `lsu_busy`=1 for 5 cycles while channel 2 is valid. Required: `req_ready`=0 throughout; grant in the first cycle with `lsu_busy`=0.
- **Reset mid-operation:** assert `reset` in WAIT. Required: next cycle all outputs are at their reset values and no `rsp_valid` is issued. After reset the channel re-requests and channel 0 has highest priority.
